pool2_seq_ctrl: RTL and testbench
=================================

// Module: pool2_seq_ctrl
// PURPOSE
//  Sequencer for the 2x2 pooling stage of the NICE coprocessor. On start it streams a feature map
//  from the source buffer into the pool datapath and writes pooled results to the destination buffer.
//  It then waits for the datapath's pool_end and reports done/timeout to the NICE command logic.
// PARAMETERS
//  DW          96   data word width (source, datapath and destination buffers)
//  AW          10   buffer address width; all address arithmetic is modulo 2^AW
//  DRAIN_TO    64   max cycles in DRAIN waiting for pool_end before timeout
// PORTS
//  clk             in   1    clock
//  rst             in   1    synchronous reset, active-high
//  start           in   1    command pulse; accepted only in IDLE
//  cfg_rows        in   8    feature-map rows; latched at start
//  cfg_cols        in   8    words per row; latched at start, also drives pool_col
//  src_base        in   AW   source buffer base address; latched at start
//  dst_base        in   AW   destination buffer base address; latched at start
//  src_stall       in   1    high: no source read is issued this cycle
//  busy            out  1    high from the cycle after start is accepted until DONE is left
//  done            out  1    one-cycle pulse in DONE
//  err_timeout     out  1    sticky; set on drain timeout, cleared when the next start is accepted
//  rd_en           out  1    source read strobe
//  rd_addr         out  AW   source read address
//  rd_data         in   DW   source read data, valid the cycle after rd_en
//  pool_en         out  1    pool datapath enable
//  pool_col        out  16   column count to datapath = {8'd0, cfg_cols latched}
//  pool_valid_in   out  1    datapath input valid
//  pool_data_in    out  DW   datapath input data
//  pool_valid_out  in   1    datapath result valid
//  pool_data_out   in   DW   datapath result
//  pool_end        in   1    datapath finished pulse
//  wr_en           out  1    destination write strobe
//  wr_addr         out  AW   destination write address
//  wr_data         out  DW   destination write data
// BEHAVIOUR
//  - Reset: every output and counter is 0 and the state is IDLE on the next edge. This applies
//    mid-operation: pool_en drops and any in-flight read is discarded.
//  - States are IDLE, FEED, DRAIN and DONE. N = cfg_rows*cfg_cols, computed as 16 bits.
//  - IDLE:
//    - start accepted: latch cfg, clear err_timeout and all counters.
//    - N==0: go to DONE with no reads issued.
//    - Otherwise go to FEED.
//    - start in any other state is ignored.
//  - FEED:
//    - pool_en=1.
//    - Each cycle with !src_stall and issued<N: rd_en=1, rd_addr=src_base+issued, issued++.
//  - Input pipeline:
//    - pool_valid_in = rd_en delayed 1 cycle; pool_data_in = rd_data in that cycle.
//    - Latency rd_en -> pool_valid_in is exactly 1 cycle.
//    - A stall only gaps reads; a read already issued is still delivered.
//  - FEED -> DRAIN in the cycle after the last read, i.e. when the last pool_valid_in is presented.
//  - Output path: registered, 1 cycle.
//    - pool_valid_out at cycle t gives wr_en=1 at t+1, with wr_data=pool_data_out and
//      wr_addr=dst_base+wcnt; wcnt then increments.
//    - Results are written in FEED and DRAIN only; pool_valid_out in IDLE or DONE is ignored.
//  - pool_end:
//    - Latched into end_seen whenever it arrives in FEED or DRAIN. An early arrival is kept,
//      and DRAIN exits on its first cycle.
//  - DRAIN:
//    - pool_en=1; the timeout counter increments each cycle.
//    - end_seen: go to DONE.
//    - Counter reaches DRAIN_TO-1 without end_seen: set err_timeout, go to DONE.
//    - A pool_end in the same cycle as timeout wins: no error.
//  - DONE:
//    - Lasts exactly 1 cycle: done=1, pool_en=0, busy=1.
//    - Then IDLE with busy=0; a start in that IDLE cycle is accepted.
//    - The last pending wr_en still fires in the DONE cycle.
//  - Address wrap: src_base+issued and dst_base+wcnt wrap modulo 2^AW silently.
// TESTING
//  - Rows 4, cols 4, no stall: rd_en for 16 consecutive cycles at addresses base..base+15.
//    pool_valid_in follows each 1 cycle later; with pool_end 5 cycles after the last input,
//    done pulses exactly once and busy falls the next cycle.
//  - src_stall high for 3 cycles mid-FEED: the read sequence pauses and resumes with no address
//    skipped or repeated; 16 total reads.
//  - rows=0: done 1 cycle after the DONE entry decision, zero rd_en, err_timeout=0.
//  - pool_end never asserted: err_timeout=1 after DRAIN_TO cycles in DRAIN and done pulses.
//    The next start clears err_timeout.
//  - src_base=2^AW-2 with 4 words: rd_addr sequence 1022, 1023, 0, 1.
//    dst writes wrap likewise from dst_base=1023.
//  - rst=1 in the 5th FEED cycle: next edge shows all outputs 0, IDLE state, no done.
//    A later start runs a full clean pass.

Source files
------------

// File: rtl/pool2_seq_ctrl_if.sv
// rtl/pool2_seq_ctrl_if.sv - Command, source, datapath and destination signals of the 2x2 pool sequencer
interface pool2_seq_ctrl_if #(
   parameter int DW = 96,
   parameter int AW = 10
);
   logic          start;
   logic [7:0]    cfg_rows;
   logic [7:0]    cfg_cols;
   logic [AW-1:0] src_base;
   logic [AW-1:0] dst_base;
   logic          src_stall;
   logic          busy;
   logic          done;
   logic          err_timeout;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          pool_en;
   logic [15:0]   pool_col;
   logic          pool_valid_in;
   logic [DW-1:0] pool_data_in;
   logic          pool_valid_out;
   logic [DW-1:0] pool_data_out;
   logic          pool_end;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   modport master (
      input  start, cfg_rows, cfg_cols, src_base, dst_base, src_stall,
             rd_data, pool_valid_out, pool_data_out, pool_end,
      output busy, done, err_timeout, rd_en, rd_addr, pool_en, pool_col,
             pool_valid_in, pool_data_in, wr_en, wr_addr, wr_data
   );

   modport slave (
      output start, cfg_rows, cfg_cols, src_base, dst_base, src_stall,
             rd_data, pool_valid_out, pool_data_out, pool_end,
      input  busy, done, err_timeout, rd_en, rd_addr, pool_en, pool_col,
             pool_valid_in, pool_data_in, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/pool2_seq_ctrl.sv
// rtl/pool2_seq_ctrl.sv - 2x2 pooling stage sequencer: feeds source words, writes results, waits for pool_end
module pool2_seq_ctrl #(
   parameter int DW       = 96,
   parameter int AW       = 10,
   parameter int DRAIN_TO = 64
) (
   input  logic               clk,
   input  logic               rst,
   pool2_seq_ctrl_if.master   bus
);
   localparam int TW = $clog2(DRAIN_TO + 1);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

   state_t        state;
   logic [7:0]    rows_q;
   logic [7:0]    cols_q;
   logic [AW-1:0] src_q;
   logic [AW-1:0] dst_q;
   logic [15:0]   issued;
   logic [AW-1:0] wcnt;
   logic [TW-1:0] tcnt;
   logic          end_seen;
   logic          busy_q;
   logic          done_q;
   logic          err_q;
   logic          pool_en_q;
   logic          pv_in_q;
   logic          wr_en_q;
   logic [AW-1:0] wr_addr_q;
   logic [DW-1:0] wr_data_q;

   logic [15:0]   total;
   logic [15:0]   n_in;
   logic          rd_go;
   logic          active;

   assign total  = {8'd0, rows_q} * {8'd0, cols_q};
   assign n_in   = {8'd0, bus.cfg_rows} * {8'd0, bus.cfg_cols};
   assign active = (state == FEED) || (state == DRAIN);
   assign rd_go  = (state == FEED) && !bus.src_stall && (issued < total);

   // Read strobe reacts to src_stall in the same cycle, so it stays combinational.
   assign bus.rd_en         = rd_go;
   assign bus.rd_addr       = rd_go ? (src_q + issued[AW-1:0]) : '0;
   assign bus.pool_valid_in = pv_in_q;
   assign bus.pool_data_in  = pv_in_q ? bus.rd_data : '0;
   assign bus.pool_en       = pool_en_q;
   assign bus.pool_col      = {8'd0, cols_q};
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.err_timeout   = err_q;
   assign bus.wr_en         = wr_en_q;
   assign bus.wr_addr       = wr_addr_q;
   assign bus.wr_data       = wr_data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rows_q    <= '0;
         cols_q    <= '0;
         src_q     <= '0;
         dst_q     <= '0;
         issued    <= '0;
         wcnt      <= '0;
         tcnt      <= '0;
         end_seen  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         pool_en_q <= 1'b0;
         pv_in_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         pv_in_q <= rd_go;
         wr_en_q <= bus.pool_valid_out && active;
         if (bus.pool_valid_out && active) begin
            wr_addr_q <= dst_q + wcnt;
            wr_data_q <= bus.pool_data_out;
            wcnt      <= wcnt + 1'b1;
         end
         if (bus.pool_end && active)
            end_seen <= 1'b1;

         case (state)
            IDLE: begin
               if (bus.start) begin
                  rows_q   <= bus.cfg_rows;
                  cols_q   <= bus.cfg_cols;
                  src_q    <= bus.src_base;
                  dst_q    <= bus.dst_base;
                  issued   <= '0;
                  wcnt     <= '0;
                  tcnt     <= '0;
                  end_seen <= 1'b0;
                  err_q    <= 1'b0;
                  busy_q   <= 1'b1;
                  if (n_in == 16'd0) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     state     <= FEED;
                     pool_en_q <= 1'b1;
                  end
               end
            end
            FEED: begin
               if (rd_go) begin
                  issued <= issued + 16'd1;
                  if (issued == total - 16'd1)
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               // A pool_end arriving on the timeout cycle still counts as a clean finish.
               if (end_seen || bus.pool_end) begin
                  state     <= DONE;
                  done_q    <= 1'b1;
                  pool_en_q <= 1'b0;
               end else if (tcnt == TW'(DRAIN_TO - 1)) begin
                  state     <= DONE;
                  done_q    <= 1'b1;
                  pool_en_q <= 1'b0;
                  err_q     <= 1'b1;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pool2_seq_ctrl.sv
// tb/tb_pool2_seq_ctrl.sv - Randomized self-checking bench for pool2_seq_ctrl against a job-timeline model
module tb_pool2_seq_ctrl;
   localparam int DW = 96;
   localparam int AW = 10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pool2_seq_ctrl_if #(.DW(DW), .AW(AW)) bus ();

   pool2_seq_ctrl #(.DW(DW), .AW(AW), .DRAIN_TO(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [DW-1:0] src_mem [1024];
   bit            last_ren;
   logic [AW-1:0] last_ra;
   bit            prev_err;
   logic [7:0]    prev_cols;

   bit            st  [256];
   bit            pv  [256];
   logic [DW-1:0] pd  [256];
   bit            erd [256];
   logic [AW-1:0] era [256];
   bit            ewr [256];
   logic [AW-1:0] ewa [256];
   logic [DW-1:0] ewd [256];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd_word();
      return {$urandom, $urandom, $urandom};
   endfunction

   // One clock cycle: inputs change 1 time unit after the edge, outputs are read at the falling edge.
   task automatic drive(input bit st_v, input logic [7:0] rows, input logic [7:0] cols,
                        input logic [AW-1:0] sb, input logic [AW-1:0] db, input bit stall,
                        input bit pe, input bit pvo, input logic [DW-1:0] pdo, input bit rst_v);
      @(posedge clk);
      #1;
      rst                = rst_v;
      bus.rd_data        = last_ren ? src_mem[last_ra] : rnd_word();
      bus.start          = st_v;
      bus.cfg_rows       = rows;
      bus.cfg_cols       = cols;
      bus.src_base       = sb;
      bus.dst_base       = db;
      bus.src_stall      = stall;
      bus.pool_end       = pe;
      bus.pool_valid_out = pvo;
      bus.pool_data_out  = pdo;
      @(negedge clk);
      last_ren = bus.rd_en;
      last_ra  = bus.rd_addr;
   endtask

   task automatic check_zero(input string tag);
      check({tag, " rd_en"},         bus.rd_en, 0);
      check({tag, " rd_addr"},       bus.rd_addr, 0);
      check({tag, " pool_en"},       bus.pool_en, 0);
      check({tag, " pool_col"},      bus.pool_col, 0);
      check({tag, " pool_valid_in"}, bus.pool_valid_in, 0);
      check({tag, " pool_data_in"},  bus.pool_data_in, 0);
      check({tag, " busy"},          bus.busy, 0);
      check({tag, " done"},          bus.done, 0);
      check({tag, " err_timeout"},   bus.err_timeout, 0);
      check({tag, " wr_en"},         bus.wr_en, 0);
      check({tag, " wr_addr"},       bus.wr_addr, 0);
      check({tag, " wr_data"},       bus.wr_data, 0);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 8'($urandom), 8'($urandom), AW'($urandom), AW'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), rnd_word(), 1'b0);
         check($sformatf("idle%0d busy", i),    bus.busy, 0);
         check($sformatf("idle%0d done", i),    bus.done, 0);
         check($sformatf("idle%0d rd_en", i),   bus.rd_en, 0);
         check($sformatf("idle%0d pool_en", i), bus.pool_en, 0);
         check($sformatf("idle%0d wr_en", i),   bus.wr_en, 0);
         check($sformatf("idle%0d err", i),     bus.err_timeout, prev_err);
      end
   endtask

   // Job timeline, r = cycles since the start cycle (r=0):
   //   reads in FEED cycles r>=1 without stall; L = last read cycle; DRAIN runs from L+1.
   //   pool_end at cycle P: done at L+2 if P<=L+1, at P+1 if P<=L+64, else timeout with done at L+65.
   //   pool_valid_out at r in [1, done-1] is written at r+1 to consecutive destination addresses.
   // smode: 0 no stall, 1 stall r=6..8, 2 random. pmode: 0 P=L+1+pval, 1 never, 2 P=pval (early).
   task automatic run_job(input int rows, input int cols, input int sb, input int db,
                          input int smode, input int pmode, input int pval);
      int n, k, L, P, D, j;
      bit err_new;
      for (int r = 0; r < 256; r++) begin
         erd[r] = 0; era[r] = '0; ewr[r] = 0; ewa[r] = '0; ewd[r] = '0; pv[r] = 0; pd[r] = '0;
         st[r] = (r == 0) ? 1'b0 :
                 (smode == 1) ? (r >= 6 && r <= 8) :
                 (smode == 2) ? ($urandom_range(0, 9) < 3 && r < 150) : 1'b0;
      end
      n = rows * cols;
      k = 0;
      L = 0;
      for (int r = 1; r < 256 && k < n; r++) begin
         if (!st[r]) begin
            erd[r] = 1;
            era[r] = AW'(sb + k);
            k++;
            L = r;
         end
      end
      if (n == 0) begin
         P = -1; D = 1; err_new = 0;
      end else begin
         if (pmode == 0)      P = L + 1 + pval;
         else if (pmode == 1) P = -1;
         else                 P = (pval < 1) ? 1 : ((pval > L) ? L : pval);
         err_new = (P < 1) || (P > L + 64);
         D = err_new ? L + 65 : ((P <= L + 1) ? L + 2 : P + 1);
      end
      for (int r = 0; r <= D; r++) begin
         pv[r] = 1'($urandom);
         pd[r] = rnd_word();
      end
      j = 0;
      for (int r = 1; r < D; r++) begin
         if (pv[r]) begin
            ewr[r+1] = 1;
            ewa[r+1] = AW'(db + j);
            ewd[r+1] = pd[r];
            j++;
         end
      end
      for (int r = 0; r <= D; r++) begin
         if (r == 0)
            drive(1'b1, 8'(rows), 8'(cols), AW'(sb), AW'(db), st[r], 1'b0, pv[r], pd[r], 1'b0);
         else
            drive($urandom_range(0, 3) == 0, 8'($urandom), 8'($urandom), AW'($urandom),
                  AW'($urandom), st[r], r == P, pv[r], pd[r], 1'b0);
         check($sformatf("r%0d rd_en", r), bus.rd_en, erd[r]);
         if (erd[r])
            check($sformatf("r%0d rd_addr", r), bus.rd_addr, era[r]);
         if (r >= 1 && erd[r-1]) begin
            check($sformatf("r%0d pool_valid_in", r), bus.pool_valid_in, 1);
            check($sformatf("r%0d pool_data_in", r), bus.pool_data_in, src_mem[era[r-1]]);
         end else begin
            check($sformatf("r%0d pool_valid_in", r), bus.pool_valid_in, 0);
         end
         check($sformatf("r%0d wr_en", r), bus.wr_en, ewr[r]);
         if (ewr[r]) begin
            check($sformatf("r%0d wr_addr", r), bus.wr_addr, ewa[r]);
            check($sformatf("r%0d wr_data", r), bus.wr_data, ewd[r]);
         end
         check($sformatf("r%0d done", r), bus.done, r == D);
         check($sformatf("r%0d busy", r), bus.busy, r >= 1);
         check($sformatf("r%0d pool_en", r), bus.pool_en, (r >= 1) && (r < D) && (n != 0));
         check($sformatf("r%0d err_timeout", r), bus.err_timeout,
               (r == 0) ? prev_err : ((r < D) ? 1'b0 : err_new));
         check($sformatf("r%0d pool_col", r), bus.pool_col,
               (r == 0) ? {8'd0, prev_cols} : 16'(cols));
      end
      prev_err  = err_new;
      prev_cols = 8'(cols);
   endtask

   task automatic reset_mid_feed();
      drive(1'b1, 8'd4, 8'd4, 10'd33, 10'd44, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      for (int r = 1; r <= 4; r++)
         drive(1'b0, 8'd0, 8'd0, '0, '0, 1'b0, 1'b0, 1'($urandom), rnd_word(), 1'b0);
      drive(1'b0, 8'd0, 8'd0, '0, '0, 1'b0, 1'b0, 1'b1, rnd_word(), 1'b1);
      drive(1'b0, 8'd0, 8'd0, '0, '0, 1'b0, 1'b1, 1'b1, rnd_word(), 1'b0);
      check_zero("midrst");
      prev_err  = 0;
      prev_cols = 8'd0;
      idle_cycles(3);
   endtask

   initial begin
      int rows, cols, sel, pm, pval;
      for (int i = 0; i < 1024; i++)
         src_mem[i] = rnd_word();
      last_ren  = 0;
      last_ra   = '0;
      prev_err  = 0;
      prev_cols = 8'd0;
      rst                = 1'b1;
      bus.start          = 1'b0;
      bus.cfg_rows       = '0;
      bus.cfg_cols       = '0;
      bus.src_base       = '0;
      bus.dst_base       = '0;
      bus.src_stall      = 1'b0;
      bus.rd_data        = '0;
      bus.pool_valid_out = 1'b0;
      bus.pool_data_out  = '0;
      bus.pool_end       = 1'b0;

      drive(1'b0, 8'd0, 8'd0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      drive(1'b1, 8'd3, 8'd3, 10'd1, 10'd1, 1'b0, 1'b1, 1'b1, rnd_word(), 1'b1);
      check_zero("reset");
      idle_cycles(2);

      run_job(4, 4, 5, 100, 0, 0, 5);
      run_job(4, 4, 200, 300, 1, 0, 2);
      run_job(0, 5, 7, 8, 0, 0, 0);
      run_job(2, 3, 50, 60, 0, 1, 0);
      run_job(1, 2, 10, 20, 0, 0, 1);
      run_job(1, 4, 1022, 1023, 0, 0, 3);
      run_job(3, 3, 0, 0, 2, 2, 3);
      run_job(2, 2, 9, 9, 0, 0, 63);
      idle_cycles(1);

      reset_mid_feed();
      run_job(4, 4, 600, 700, 0, 0, 4);

      for (int t = 0; t < 12; t++) begin
         rows = $urandom_range(0, 5);
         cols = $urandom_range(0, 6);
         sel  = $urandom_range(0, 9);
         if (sel < 7)       begin pm = 0; pval = $urandom_range(0, 12); end
         else if (sel == 7) begin pm = 1; pval = 0; end
         else if (sel == 8) begin pm = 2; pval = $urandom_range(1, 30); end
         else               begin pm = 0; pval = $urandom_range(62, 64); end
         run_job(rows, cols, $urandom_range(0, 1023), $urandom_range(0, 1023),
                 $urandom_range(0, 2), pm, pval);
         idle_cycles($urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
